// File: rtl/prog_clk_gen_if.sv
// Configuration handshake bundle for the programmable clock generator.
// Combinational wires only; no latency of its own.
// The slave holds cfg_ready low while a configuration is waiting to be applied.
interface prog_clk_gen_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_high,
    output cfg_ready
  );
endinterface

// File: rtl/prog_clk_gen.sv
// Programmable clock divider: period/high time set through a valid/ready port.
// clk_out and tick are registered, one clk_in cycle behind the counter.
// One configuration is held in shadow; cfg_ready drops until it applies at a wrap.
module prog_clk_gen #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 6
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            en,
  prog_clk_gen_if.slave   cfg,
  output logic            clk_out,
  output logic            tick,
  output logic            cfg_clamped
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] shd_period;
  logic [CNT_W-1:0] shd_high;
  logic             pending;

  logic             wrap;
  logic             accept;
  logic             apply;
  logic             need_clamp;
  logic [CNT_W-1:0] req_period;
  logic [CNT_W-1:0] req_high;

  assign cfg.cfg_ready = !pending;

  // Decode wrap/accept/apply and condition the requested configuration.
  // A high time at or above the requested period saturates to the stored
  // period, so a clamped period still yields a constant-high output; a zero
  // high time always stays zero (constant-low output).
  always_comb begin
    wrap       = en && (cnt == act_period - ONE);
    accept     = cfg.cfg_valid && !pending;
    apply      = pending && (wrap || !en);
    need_clamp = cfg.cfg_period < MIN_P;
    req_period = need_clamp ? MIN_P : cfg.cfg_period;
    req_high   = cfg.cfg_high;
    if (cfg.cfg_high == '0) begin
      req_high = '0;
    end else if (cfg.cfg_high >= cfg.cfg_period) begin
      req_high = req_period;
    end
  end

  // Period counter and registered outputs; everything parks at 0 while disabled.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      cnt     <= wrap ? '0 : cnt + ONE;
      clk_out <= (cnt < act_high);
      tick    <= wrap;
    end else begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
  end

  // Active settings change only at a period boundary (or while stopped).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      act_period <= DEF_P;
      act_high   <= DEF_H;
    end else if (apply) begin
      act_period <= shd_period;
      act_high   <= shd_high;
    end
  end

  // Shadow capture, pending flag and the clamp notification pulse.
  // accept needs !pending and apply needs pending, so they never coincide;
  // a configuration accepted on a wrap therefore waits for the next wrap.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shd_period  <= DEF_P;
      shd_high    <= DEF_H;
      pending     <= 1'b0;
      cfg_clamped <= 1'b0;
    end else begin
      cfg_clamped <= accept && need_clamp;
      if (accept) begin
        shd_period <= req_period;
        shd_high   <= req_high;
        pending    <= 1'b1;
      end else if (apply) begin
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Directed bench for prog_clk_gen; sequences are packed oldest-sample-first
// (MSB = first cycle sampled) and compared with hand-derived constants.
// Outputs are sampled 1 time unit after each rising edge of clk_in.
module tb_prog_clk_gen;

  logic clk_in;
  logic reset;
  logic en;
  logic clk_out;
  logic tick;
  logic cfg_clamped;

  int n_vec;
  int n_err;

  prog_clk_gen_if #(.CNT_W(8)) cfg_if ();

  prog_clk_gen #(
    .CNT_W      (8),
    .DEF_PERIOD (10),
    .DEF_HIGH   (6)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .en          (en),
    .cfg         (cfg_if.slave),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_clamped (cfg_clamped)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the sampling point.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Run n edges, collecting clk_out, tick, cfg_ready and cfg_clamped.
  task automatic run(input int n, output logic [31:0] c_v, output logic [31:0] t_v,
                     output logic [31:0] r_v, output logic [31:0] k_v);
    c_v = '0; t_v = '0; r_v = '0; k_v = '0;
    for (int i = 0; i < n; i++) begin
      step();
      c_v = {c_v[30:0], clk_out};
      t_v = {t_v[30:0], tick};
      r_v = {r_v[30:0], cfg_if.cfg_ready};
      k_v = {k_v[30:0], cfg_clamped};
    end
  endtask

  task automatic offer(input logic [7:0] p, input logic [7:0] h);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = p;
    cfg_if.cfg_high   = h;
  endtask

  logic [31:0] cv, tv, rv, kv;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    en    = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = 8'd0;
    cfg_if.cfg_high   = 8'd0;

    // Reset state
    repeat (2) step();
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("rst_clamped", {31'd0, cfg_clamped}, 32'd0);

    // Defaults: 6 high / 4 low, tick every 10 (edges 1..20)
    reset = 1'b0;
    en    = 1'b1;
    run(20, cv, tv, rv, kv);
    chk("def_clk", cv, 32'hFC3F0);
    chk("def_tick", tv, 32'h00401);
    chk("def_clamped", kv, 32'h0);

    // Mid-period reconfigure to 4/1 at cnt=3 (edge 24)
    repeat (3) step();
    offer(8'd4, 8'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("p4_ready_after_accept", {31'd0, cfg_if.cfg_ready}, 32'd0);
    run(14, cv, tv, rv, kv);
    chk("p4_clk", cv, 32'h3088);
    chk("p4_tick", tv, 32'h0111);
    chk("p4_ready", rv, 32'h01FF);

    // Period 1 clamped to 2, high saturates; second offer while pending ignored
    offer(8'd1, 8'd1);
    step();
    chk("clamp_pulse", {31'd0, cfg_clamped}, 32'd1);
    chk("clamp_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    offer(8'd7, 8'd3);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("clamp_pulse_end", {31'd0, cfg_clamped}, 32'd0);
    chk("clamp_clk_e40", {31'd0, clk_out}, 32'd0);
    run(15, cv, tv, rv, kv);
    chk("p2_clk", cv, 32'h1FFF);
    chk("p2_tick", tv, 32'h2AAA);
    chk("p2_clamped", kv, 32'h0);

    // Accept on a wrap cycle: applies at the following wrap, not this one
    offer(8'd8, 8'd3);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("wrap_acc_tick", {31'd0, tick}, 32'd1);
    chk("wrap_acc_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    run(4, cv, tv, rv, kv);
    chk("wrap_acc_tick_seq", tv, 32'h4);
    chk("wrap_acc_clk_seq", cv, 32'hF);
    chk("wrap_acc_ready_seq", rv, 32'h7);

    // Pending 9/7 accepted at cnt=2, disable with cnt=3, re-enable
    offer(8'd9, 8'd7);
    step();
    cfg_if.cfg_valid = 1'b0;
    en = 1'b0;
    chk("dis_pre_clk", {31'd0, clk_out}, 32'd1);
    chk("dis_pre_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    run(3, cv, tv, rv, kv);
    chk("dis_clk", cv, 32'h0);
    chk("dis_tick", tv, 32'h0);
    chk("dis_ready", rv, 32'h7);
    en = 1'b1;
    run(10, cv, tv, rv, kv);
    chk("p9_clk", cv, 32'h3F9);
    chk("p9_tick", tv, 32'h002);

    // Reset at cnt=5 with 3/1 pending: async clear, defaults afterwards
    step();
    offer(8'd3, 8'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_clk", {31'd0, clk_out}, 32'd1);
    chk("pre_rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_clk", {31'd0, clk_out}, 32'd0);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    chk("async_rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step();
    reset = 1'b0;
    run(20, cv, tv, rv, kv);
    chk("post_rst_clk", cv, 32'hFC3F0);
    chk("post_rst_tick", tv, 32'h00401);
    chk("post_rst_ready", rv, 32'hFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_clk_gen.md
PROG_CLK_GEN -- requirements
Module: prog_clk_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the counter, period and high fields.
REQ-002 Parameter DEF_PERIOD, default 10: active period, in clk_in cycles, after reset.
REQ-003 Parameter DEF_HIGH, default 6: active high time, in clk_in cycles, after reset.
REQ-004 Port clk_in  input  1: clock; all logic is rising-edge triggered.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  1: run enable.
REQ-007 Port cfg_valid  input  1: new configuration offered.
REQ-008 Port cfg_period  input  CNT_W: requested period, in cycles.
REQ-009 Port cfg_high  input  CNT_W: requested high time, in cycles.
REQ-010 Port cfg_ready  output  1: the block can accept a configuration.
REQ-011 Port clk_out  output  1: generated clock, registered.
REQ-012 Port tick  output  1: one-cycle pulse at each period wrap, registered.
REQ-013 Port cfg_clamped  output  1: one-cycle pulse when an accepted period was clamped.

Function
REQ-014 The block SHALL hold an internal counter cnt (0..act_period-1) and active registers act_period and act_high.
REQ-015 While en=1, each cycle cnt SHALL increment, returning to 0 on the cycle after cnt=act_period-1 (wrap cycle).
REQ-016 While en=1, each cycle clk_out SHALL load (cnt < act_high), computed from the pre-update cnt, giving one cycle of latency.
REQ-017 tick SHALL be 1 in the cycle following a wrap cycle and 0 otherwise.
REQ-018 The configuration is accepted on the cycle where cfg_valid=1 and cfg_ready=1; the block SHALL capture it into shadow registers and set pending=1.
REQ-019 cfg_ready SHALL equal !pending.
REQ-020 cfg_valid asserted while cfg_ready=0 SHALL be ignored; the shadow registers SHALL be unchanged.
REQ-021 When en=1, a pending configuration SHALL transfer to the active registers only on a wrap cycle, with cnt going to 0 and pending cleared in that same edge, so that no truncated or extended period is ever produced.
REQ-022 Acceptance and wrap in the same cycle SHALL NOT apply the new values at that wrap; they apply at the next wrap.
REQ-023 An accepted cfg_period < 2 SHALL be stored as 2.
REQ-024 cfg_clamped SHALL pulse in the cycle after an acceptance that required clamping.
REQ-025 cfg_high >= period SHALL give clk_out constant 1 with tick still pulsing.
REQ-026 cfg_high = 0 SHALL give clk_out constant 0 with tick still pulsing.
REQ-027 While en=0: cnt SHALL be held at 0, clk_out and tick SHALL be 0 from the next cycle, and a pending configuration SHALL be applied on the next edge.
REQ-028 On a 0->1 transition of en, the period SHALL start from cnt=0, with clk_out going high on the next edge if act_high > 0.
REQ-029 All arithmetic SHALL be unsigned, CNT_W wide, with no overflow, because cnt never exceeds act_period-1.

Reset
REQ-030 On reset assertion, the block SHALL immediately set cnt=0, clk_out=0, tick=0, cfg_clamped=0, pending=0 (so cfg_ready=1), act_period=DEF_PERIOD and act_high=DEF_HIGH.
REQ-031 A reset asserted mid-period SHALL discard any pending configuration; the first post-reset period SHALL use the defaults.

Verification
REQ-032 Reset released, en=1, defaults -> clk_out repeats 6 high / 4 low; tick pulses every 10 cycles.
REQ-033 Mid-period, accept period=4, high=1 -> cfg_ready=0 until the wrap; the old 10-cycle period completes, then a 1-high/3-low pattern follows and cfg_ready returns to 1.
REQ-034 Accept period=1, high=1 -> cfg_clamped pulses; the pattern becomes period 2 with clk_out constant 1.
REQ-035 A second cfg_valid while pending -> ignored; the first configuration takes effect and the second is never applied.
REQ-036 en=0 at cnt=3 with a configuration pending -> clk_out=0, the configuration is applied; en=1 -> the new period starts from cnt=0.
REQ-037 Reset asserted at cnt=5 with a configuration pending -> outputs clear asynchronously; after release the defaults produce 6/4.
